// File: rtl/booth_radix4_multiplier_if.sv
// booth_radix4_multiplier_if: handshake and operand/result bus for the radix-4 Booth multiplier
//   master (controller): drives start, signed_mode, Multiplicand, Multiplier
//                        and observes busy, ready, Product, Result, Overflow
//   slave (multiplier):  the mirror image
interface booth_radix4_multiplier_if #(parameter int W = 16);
    logic           start;
    logic           signed_mode;
    logic [W-1:0]   Multiplicand;
    logic [W-1:0]   Multiplier;
    logic           busy;
    logic           ready;
    logic [2*W-1:0] Product;
    logic [W-1:0]   Result;
    logic           Overflow;
    modport master (output start, signed_mode, Multiplicand, Multiplier,
                    input busy, ready, Product, Result, Overflow);
    modport slave  (input start, signed_mode, Multiplicand, Multiplier,
                    output busy, ready, Product, Result, Overflow);
endinterface

// File: rtl/booth_radix4_multiplier.sv
// booth_radix4_multiplier: sequential radix-4 Booth multiplier, signed/unsigned, start/ready handshake
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    slave side of booth_radix4_multiplier_if (start, signed_mode, operands in;
//          busy, ready, Product, Result, Overflow out)
//   BOOTH_SAT_EN defined: Result saturates when Overflow is set; otherwise Result wraps.
module booth_radix4_multiplier #(
    parameter int WORD_LENGTH = 16
) (
    input logic                      clk,
    input logic                      reset,
    booth_radix4_multiplier_if.slave bus
);
    localparam int W  = WORD_LENGTH;
    localparam int CW = $clog2(W/2+2);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [W+1:0]    m_q;
    logic [W+2:0]    acc_q;
    logic [W+1:0]    mr_q;
    logic            qm1_q;
    logic            signed_q;
    logic            busy_q;
    logic            ready_q;
    logic [2*W-1:0]  prod_q;
    logic [W-1:0]    res_q;
    logic            ovf_q;
    logic [2:0]      dg;
    logic [W+2:0]    m3;
    logic [W+2:0]    pp;
    logic [W+2:0]    sum;
    logic [W+2:0]    acc_d;
    logic [W+1:0]    mr_d;
    logic [2*W-1:0]  prod_d;
    logic            ovf_d;
    logic [W-1:0]    res_d;
    logic [W+1:0]    a_ext;
    logic [W+1:0]    b_ext;
    always_comb begin
        a_ext  = bus.signed_mode ? {{2{bus.Multiplicand[W-1]}}, bus.Multiplicand} : {2'b00, bus.Multiplicand};
        b_ext  = bus.signed_mode ? {{2{bus.Multiplier[W-1]}}, bus.Multiplier} : {2'b00, bus.Multiplier};
        dg     = {mr_q[1:0], qm1_q};
        m3     = {m_q[W+1], m_q};
        pp     = (dg == 3'b001 || dg == 3'b010) ? m3 :
                 (dg == 3'b011)                 ? m3 << 1 :
                 (dg == 3'b100)                 ? -(m3 << 1) :
                 (dg == 3'b101 || dg == 3'b110) ? -m3 : '0;
        sum    = acc_q + pp;
        // {acc, mr, qm1} shifted right arithmetically by one Booth digit
        acc_d  = {{2{sum[W+2]}}, sum[W+2:2]};
        mr_d   = {sum[1:0], mr_q[W+1:2]};
        prod_d = {acc_d[W-3:0], mr_d};
        ovf_d  = signed_q ? !(&prod_d[2*W-1:W-1] || !(|prod_d[2*W-1:W-1])) : |prod_d[2*W-1:W];
`ifdef BOOTH_SAT_EN
        res_d  = !ovf_d          ? prod_d[W-1:0] :
                 !signed_q       ? {W{1'b1}} :
                 prod_d[2*W-1]   ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`else
        res_d  = prod_d[W-1:0];
`endif
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            m_q      <= '0;
            acc_q    <= '0;
            mr_q     <= '0;
            qm1_q    <= 1'b0;
            signed_q <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            prod_q   <= '0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    m_q      <= a_ext;
                    mr_q     <= b_ext;
                    acc_q    <= '0;
                    qm1_q    <= 1'b0;
                    signed_q <= bus.signed_mode;
                    cnt_q    <= CW'(W/2+1);
                    busy_q   <= 1'b1;
                    state_q  <= RUN;
                end
                RUN: begin
                    acc_q <= acc_d;
                    mr_q  <= mr_d;
                    qm1_q <= mr_q[1];
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        prod_q  <= prod_d;
                        res_q   <= res_d;
                        ovf_q   <= ovf_d;
                        ready_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.busy     = busy_q;
    assign bus.ready    = ready_q;
    assign bus.Product  = prod_q;
    assign bus.Result   = res_q;
    assign bus.Overflow = ovf_q;
endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// tb_booth_radix4_multiplier: directed vector table plus handshake/reset sequences, W = 16
module tb_booth_radix4_multiplier;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;
`ifdef BOOTH_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    booth_radix4_multiplier_if #(.W(16)) bus ();
    booth_radix4_multiplier #(.WORD_LENGTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );
    always #5 clk = ~clk;
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        sm;
        logic [31:0] p;
        logic [15:0] r_wrap;
        logic [15:0] r_sat;
        logic        ov;
    } vec_t;
    vec_t v [0:13];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask
    // Issue one operation from IDLE; lat = edges from start-sampling edge to ready seen.
    task automatic mult(input logic [15:0] a, input logic [15:0] b, input logic sm, output int lat);
        @(negedge clk);
        bus.Multiplicand = a;
        bus.Multiplier   = b;
        bus.signed_mode  = sm;
        bus.start        = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        while (!bus.ready && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask
    initial begin
        int lat;
        int rdy;
        v[0]  = '{16'h8008, 16'h0002, 1'b1, 32'hFFFF0010, 16'h0010, 16'h8000, 1'b1};
        v[1]  = '{16'h007B, 16'hFFD3, 1'b1, 32'hFFFFEA61, 16'hEA61, 16'hEA61, 1'b0};
        v[2]  = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 16'h0001, 16'hFFFF, 1'b1};
        v[3]  = '{16'h8000, 16'h8000, 1'b1, 32'h40000000, 16'h0000, 16'h7FFF, 1'b1};
        v[4]  = '{16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE, 16'hFFFE, 16'hFFFE, 1'b0};
        v[5]  = '{16'hFFFF, 16'h0002, 1'b0, 32'h0001FFFE, 16'hFFFE, 16'hFFFF, 1'b1};
        v[6]  = '{16'h0003, 16'hFFFD, 1'b1, 32'hFFFFFFF7, 16'hFFF7, 16'hFFF7, 1'b0};
        v[7]  = '{16'd100,  16'd200,  1'b0, 32'h00004E20, 16'h4E20, 16'h4E20, 1'b0};
        v[8]  = '{16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF0001, 16'h0001, 16'h7FFF, 1'b1};
        v[9]  = '{16'h1234, 16'h0010, 1'b0, 32'h00012340, 16'h2340, 16'hFFFF, 1'b1};
        v[10] = '{16'h0000, 16'h8000, 1'b1, 32'h00000000, 16'h0000, 16'h0000, 1'b0};
        v[11] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 16'h0001, 16'h0001, 1'b0};
        v[12] = '{16'hFFFE, 16'h4000, 1'b1, 32'hFFFF8000, 16'h8000, 16'h8000, 1'b0};
        v[13] = '{16'h0002, 16'h4000, 1'b1, 32'h00008000, 16'h8000, 16'h7FFF, 1'b1};
        bus.start = 1'b0;
        bus.signed_mode = 1'b0;
        bus.Multiplicand = '0;
        bus.Multiplier = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_product", bus.Product, 32'h0);
        chk("reset_result", {16'h0, bus.Result}, 32'h0);
        chk("reset_flags", {29'h0, bus.Overflow, bus.busy, bus.ready}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 14; i++) begin
            mult(v[i].a, v[i].b, v[i].sm, lat);
            chk($sformatf("v%0d_latency", i), lat, 9);
            chk($sformatf("v%0d_product", i), bus.Product, v[i].p);
            chk($sformatf("v%0d_result", i), {16'h0, bus.Result}, {16'h0, SAT ? v[i].r_sat : v[i].r_wrap});
            chk($sformatf("v%0d_overflow", i), {31'h0, bus.Overflow}, {31'h0, v[i].ov});
            chk($sformatf("v%0d_busy_done", i), {31'h0, bus.busy}, 32'h1);
            @(posedge clk); #1;
            chk($sformatf("v%0d_hold", i), bus.Product, v[i].p);
        end
        // start held high with changed operands during RUN: one pulse, first operands used
        @(negedge clk);
        bus.Multiplicand = 16'd100;
        bus.Multiplier   = 16'd200;
        bus.signed_mode  = 1'b0;
        bus.start        = 1'b1;
        @(posedge clk); #1;
        bus.Multiplicand = 16'd7;
        bus.Multiplier   = 16'd7;
        rdy = 0;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            if (bus.ready) rdy++;
        end
        chk("busy_start_pulses", rdy, 1);
        chk("busy_start_ready_edge9", {31'h0, bus.ready}, 32'h1);
        chk("busy_start_product", bus.Product, 32'h00004E20);
        @(posedge clk); #1;
        chk("busy_start_idle", {30'h0, bus.busy, bus.ready}, 32'h0);
        @(posedge clk); #1;
        chk("busy_start_accept", {31'h0, bus.busy}, 32'h1);
        chk("busy_start_not_cleared", bus.Product, 32'h00004E20);
        bus.start = 1'b0;
        lat = 0;
        while (!bus.ready && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("second_latency", lat, 9);
        chk("second_product", bus.Product, 32'h00000031);
        @(posedge clk); #1;
        // reset on the 4th RUN cycle
        @(negedge clk);
        bus.Multiplicand = 16'd100;
        bus.Multiplier   = 16'd200;
        bus.start        = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_product", bus.Product, 32'h0);
        chk("abort_result", {16'h0, bus.Result}, 32'h0);
        chk("abort_flags", {29'h0, bus.Overflow, bus.busy, bus.ready}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        rdy = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.ready || bus.busy) rdy++;
        end
        chk("abort_no_ready", rdy, 0);
        mult(16'h0003, 16'hFFFD, 1'b1, lat);
        chk("after_abort_latency", lat, 9);
        chk("after_abort_product", bus.Product, 32'hFFFFFFF7);
        @(posedge clk); #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
